// File: rtl/otter_fetch_unit.sv
// OTTER instruction-fetch stage: owns the fetch PC, issues single-outstanding word
// requests to instruction memory and buffers returned words with their PCs.
module otter_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    input  logic        STALL,
    output logic        IR_VALID,
    output logic [31:0] IR_OUT,
    output logic [31:0] PC_OUT
);
    localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW      = AW + 2;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc_r;
    logic [31:0]   req_pc_r;
    logic          outstanding_r;
    logic          discard_r;
    logic [31:0]   q_pc_r    [DEPTH];
    logic [31:0]   q_instr_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;

    logic          ir_valid_s;
    logic          pop_s;
    logic          push_s;
    logic          req_s;
    logic          grant_s;
    logic [CW-1:0] slots_s;

    // Issue/consume decisions; an in-flight non-discarded fetch already owns a slot.
    always_comb begin
        ir_valid_s = (count_r != {CW{1'b0}});
        slots_s    = count_r + ((outstanding_r && !discard_r) ? CW'(1) : CW'(0));
        pop_s      = ir_valid_s && !STALL && !REDIRECT;
        req_s      = RST_N && !REDIRECT && (!outstanding_r || IMEM_RVALID) &&
                     ((slots_s - (pop_s ? CW'(1) : CW'(0))) < DEPTH_C);
        grant_s    = req_s && IMEM_GNT;
        push_s     = IMEM_RVALID && outstanding_r && !discard_r && !REDIRECT;
    end

    assign IMEM_REQ  = req_s;
    assign IMEM_ADDR = fetch_pc_r;
    assign IR_VALID  = ir_valid_s;
    assign IR_OUT    = ir_valid_s ? q_instr_r[rd_ptr_r] : NOP;
    assign PC_OUT    = ir_valid_s ? q_pc_r[rd_ptr_r]    : 32'h0000_0000;

    // Fetch PC, in-flight tracking and stale-response discard.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fetch_pc_r    <= RESET_PC;
            req_pc_r      <= 32'h0000_0000;
            outstanding_r <= 1'b0;
            discard_r     <= 1'b0;
        end else if (REDIRECT) begin
            // A response landing in the redirect cycle is simply dropped here.
            fetch_pc_r    <= {REDIRECT_PC[31:2], 2'b00};
            outstanding_r <= outstanding_r && !IMEM_RVALID;
            discard_r     <= outstanding_r && !IMEM_RVALID;
        end else begin
            if (grant_s) begin
                req_pc_r      <= fetch_pc_r;
                fetch_pc_r    <= fetch_pc_r + 32'd4;
                outstanding_r <= 1'b1;
            end else if (IMEM_RVALID) begin
                outstanding_r <= 1'b0;
            end
            if (IMEM_RVALID && discard_r) begin
                discard_r <= 1'b0;
            end
        end
    end

    // Circular {pc, instr} queue feeding IF/ID.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_r[i]    <= 32'h0000_0000;
                q_instr_r[i] <= 32'h0000_0000;
            end
        end else if (REDIRECT) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                q_pc_r[wr_ptr_r]    <= req_pc_r;
                q_instr_r[wr_ptr_r] <= IMEM_RDATA;
                wr_ptr_r            <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_otter_fetch_unit.sv
// Directed-vector bench for otter_fetch_unit with a behavioural instruction memory
// (always grants, per-request response latency, data = addr ^ 32'hA5A5_0000).
module tb_otter_fetch_unit;
    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic        CLK;
    logic        RST_N;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        STALL;
    logic        IR_VALID;
    logic [31:0] IR_OUT;
    logic [31:0] PC_OUT;

    otter_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .STALL(STALL),
        .IR_VALID(IR_VALID), .IR_OUT(IR_OUT), .PC_OUT(PC_OUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (act=timeout, exp=finish)");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        int          lat;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_v;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vt[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // memory model state
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'h0;
    int          pcnt = 0;
    int          lat = 1;
    // per-cycle captures
    logic        c_req, c_v;
    logic [31:0] c_addr, c_ir, c_pc;

    function automatic vec_t row(logic rst, logic stall, logic redir, logic [31:0] rpc, int l,
                                 logic ereq, logic [31:0] eaddr, logic ev, logic [31:0] epc);
        vec_t r;
        r.rst = rst; r.stall = stall; r.redir = redir; r.rpc = rpc; r.lat = l;
        r.exp_req = ereq; r.exp_addr = eaddr; r.exp_v = ev; r.exp_pc = epc;
        return r;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s row %0d: act=%h exp=%h", name, idx, act, exp);
        else
            pass_cnt++;
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic cyc();
        logic granted;
        if (pend && pcnt == 1) begin
            IMEM_RVALID = 1'b1;
            IMEM_RDATA  = paddr ^ MAGIC;
        end else begin
            IMEM_RVALID = 1'b0;
            IMEM_RDATA  = 32'h0;
        end
        IMEM_GNT = 1'b1;
        #2;
        c_req = IMEM_REQ; c_addr = IMEM_ADDR;
        c_v = IR_VALID; c_ir = IR_OUT; c_pc = PC_OUT;
        granted = IMEM_REQ && IMEM_GNT;
        @(posedge CLK);
        if (IMEM_RVALID) pend = 1'b0;
        else if (pend) pcnt--;
        if (granted) begin
            pend = 1'b1; paddr = c_addr; pcnt = lat;
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST_N = 1'b0; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0;
        IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = 32'h0;
        pend = 1'b0; pcnt = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        // steady state and 5-cycle stall
        vt.push_back(row(1, 0, 0, 32'h0, 1, 1, 32'h00, 0, 32'h0));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h04, 0, 32'h0));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h08, 1, 32'h0));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h0C, 1, 32'h4));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h10, 1, 32'h8));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h14, 1, 32'hC));
        for (int k = 0; k < 5; k++)
            vt.push_back(row(0, 1, 0, 32'h0, 1, 0, 32'h0, 1, 32'h10));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h18, 1, 32'h10));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h1C, 1, 32'h14));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h20, 1, 32'h18));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h24, 1, 32'h1C));
        // redirect with stale in-flight, misaligned redirect with coincident RVALID, wrap
        vt.push_back(row(1, 0, 0, 32'h0, 1, 1, 32'h00, 0, 32'h0));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h04, 0, 32'h0));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h08, 1, 32'h0));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h0C, 1, 32'h4));
        vt.push_back(row(0, 0, 0, 32'h0, 3, 1, 32'h10, 1, 32'h8));
        vt.push_back(row(0, 0, 1, 32'h100, 1, 0, 32'h0, 1, 32'hC));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h100, 0, 32'h0));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h104, 0, 32'h0));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h108, 1, 32'h100));
        vt.push_back(row(0, 0, 1, 32'h203, 1, 0, 32'h0, 1, 32'h104));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h200, 0, 32'h0));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h204, 0, 32'h0));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h208, 1, 32'h200));
        vt.push_back(row(0, 0, 1, 32'hFFFF_FFF8, 1, 0, 32'h0, 1, 32'h204));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'hFFFF_FFF8, 0, 32'h0));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h0, 1, 32'hFFFF_FFF8));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h4, 1, 32'hFFFF_FFFC));
        vt.push_back(row(0, 0, 0, 32'h0, 1, 1, 32'h8, 1, 32'h0));

        RST_N = 1'b0;
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) begin
                do_reset();
            end
            STALL = vt[i].stall; REDIRECT = vt[i].redir; REDIRECT_PC = vt[i].rpc; lat = vt[i].lat;
            cyc();
            chk("imem_req", i, {31'h0, c_req}, {31'h0, vt[i].exp_req});
            if (vt[i].exp_req) chk("imem_addr", i, c_addr, vt[i].exp_addr);
            chk("ir_valid", i, {31'h0, c_v}, {31'h0, vt[i].exp_v});
            chk("pc_out", i, c_pc, vt[i].exp_v ? vt[i].exp_pc : 32'h0);
            chk("ir_out", i, c_ir, vt[i].exp_v ? (vt[i].exp_pc ^ MAGIC) : 32'h0000_0013);
        end

        // fill queue under stall, then asynchronous reset mid-cycle
        REDIRECT = 1'b0; STALL = 1'b1; lat = 1;
        repeat (3) cyc();
        chk("full_req", 100, {31'h0, c_req}, 32'h0);
        chk("full_valid", 100, {31'h0, c_v}, 32'h1);
        chk("full_pc", 100, c_pc, 32'h4);
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst_valid", 101, {31'h0, IR_VALID}, 32'h0);
        chk("rst_ir", 101, IR_OUT, 32'h0000_0013);
        chk("rst_pc", 101, PC_OUT, 32'h0);
        chk("rst_req", 101, {31'h0, IMEM_REQ}, 32'h0);
        do_reset();
        cyc();
        chk("restart_req", 102, {31'h0, c_req}, 32'h1);
        chk("restart_addr", 102, c_addr, 32'h0);
        cyc();
        cyc();
        chk("restart_valid", 103, {31'h0, c_v}, 32'h1);
        chk("restart_pc", 103, c_pc, 32'h0);
        chk("restart_ir", 103, c_ir, MAGIC);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
